safety_island_timer_array: RTL

Parametrised multi-channel timer unit for the safety island peripheral region. It generalises the single-timer arrangement to NumTimers independent channels. Each channel has:
- a prescaler,
- a compare register,
- one-shot or periodic mode,
- two level interrupts (compare match, overflow).
All channels are reached through one register-bus slave port, and a global start register starts any subset of channels in the same cycle.

---
 rtl/safety_island_timer_array.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/safety_island_timer_array.sv
// Multi-channel timer array for the safety island peripheral region.
// Each channel has a prescaler, a compare register, one-shot/periodic mode
// and two level interrupts (match, overflow). A single register-bus port
// reaches every channel, and a global START register can enable any subset
// of channels in the same cycle.
module safety_island_timer_array #(
   parameter int NumTimers  = 2,
   parameter int CntWidth   = 32,
   parameter int PrescWidth = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_write_i,
   input  logic [11:0]            req_addr_i,
   input  logic [31:0]            req_wdata_i,
   input  logic [3:0]             req_wstrb_i,
   output logic                   rsp_valid_o,
   output logic [31:0]            rsp_rdata_o,
   output logic                   rsp_error_o,
   output logic [2*NumTimers-1:0] irq_o
);

   localparam logic [11:0] StartAddr  = 12'h100;
   localparam logic [7:0]  NumTimersB = 8'(NumTimers);

   // Per-channel architectural state
   logic [NumTimers-1:0]  r_en;
   logic [NumTimers-1:0]  r_periodic;
   logic [NumTimers-1:0]  r_matchIe;
   logic [NumTimers-1:0]  r_ovfIe;
   logic [NumTimers-1:0]  r_match;
   logic [NumTimers-1:0]  r_ovf;
   logic [PrescWidth-1:0] r_presc [NumTimers];
   logic [PrescWidth-1:0] r_pc    [NumTimers];
   logic [CntWidth-1:0]   r_cnt   [NumTimers];
   logic [CntWidth-1:0]   r_cmp   [NumTimers];

   // Registered outputs
   logic [2*NumTimers-1:0] r_irq;
   logic                   r_rspValid;
   logic                   r_rspError;
   logic [31:0]            r_rspRdata;

   // Request decode
   logic [31:0] w_byteMask;
   logic [31:0] w_wdataMasked;
   logic [7:0]  w_chSel;
   logic [1:0]  w_regSel;
   logic        w_misaligned;
   logic        w_chHit;
   logic        w_startHit;
   logic        w_err;
   logic        w_wrEn;

   // Current image of the addressed register and the strobe-merged write value
   logic [31:0] w_rdImage;
   logic [31:0] w_wrMerged;

   // Per-channel write strobes and hardware events
   logic [NumTimers-1:0] w_wrCtrl;
   logic [NumTimers-1:0] w_wrCnt;
   logic [NumTimers-1:0] w_wrCmp;
   logic [NumTimers-1:0] w_wrStat;
   logic [NumTimers-1:0] w_start;
   logic [NumTimers-1:0] w_tick;
   logic [NumTimers-1:0] w_setMatch;
   logic [NumTimers-1:0] w_setOvf;
   logic [NumTimers-1:0] w_hwStop;
   logic [CntWidth-1:0]  w_cntHw [NumTimers];

   assign req_ready_o = 1'b1;
   assign rsp_valid_o = r_rspValid;
   assign rsp_error_o = r_rspError;
   assign rsp_rdata_o = r_rspRdata;
   assign irq_o       = r_irq;

   assign w_byteMask    = {{8{req_wstrb_i[3]}}, {8{req_wstrb_i[2]}},
                           {8{req_wstrb_i[1]}}, {8{req_wstrb_i[0]}}};
   assign w_wdataMasked = req_wdata_i & w_byteMask;
   assign w_chSel       = req_addr_i[11:4];
   assign w_regSel      = req_addr_i[3:2];
   assign w_misaligned  = |req_addr_i[1:0];
   assign w_chHit       = (w_chSel < NumTimersB);
   assign w_startHit    = (req_addr_i == StartAddr);
   assign w_err         = w_misaligned | ~(w_chHit | w_startHit);
   assign w_wrEn        = req_valid_i & req_write_i & ~w_err;

   // Build the image of the addressed register; START and unmapped space read 0
   always_comb begin
      w_rdImage = '0;
      for (int k = 0; k < NumTimers; k++) begin
         if (w_chHit && (w_chSel == 8'(k))) begin
            case (w_regSel)
               2'd0: begin
                  w_rdImage[0]              = r_en[k];
                  w_rdImage[1]              = r_periodic[k];
                  w_rdImage[2]              = r_matchIe[k];
                  w_rdImage[3]              = r_ovfIe[k];
                  w_rdImage[8 +: PrescWidth] = r_presc[k];
               end
               2'd1:    w_rdImage = 32'(r_cnt[k]);
               2'd2:    w_rdImage = 32'(r_cmp[k]);
               default: w_rdImage[1:0] = {r_ovf[k], r_match[k]};
            endcase
         end
      end
   end

   // Bytes without a strobe keep the register's current contents
   assign w_wrMerged = (w_rdImage & ~w_byteMask) | w_wdataMasked;

   // Per-channel write decode plus the prescaler tick and counter events
   always_comb begin
      w_wrCtrl   = '0;
      w_wrCnt    = '0;
      w_wrCmp    = '0;
      w_wrStat   = '0;
      w_start    = '0;
      w_tick     = '0;
      w_setMatch = '0;
      w_setOvf   = '0;
      w_hwStop   = '0;
      for (int k = 0; k < NumTimers; k++) begin
         w_cntHw[k]  = r_cnt[k];
         w_wrCtrl[k] = w_wrEn && w_chHit && (w_chSel == 8'(k)) && (w_regSel == 2'd0);
         w_wrCnt[k]  = w_wrEn && w_chHit && (w_chSel == 8'(k)) && (w_regSel == 2'd1);
         w_wrCmp[k]  = w_wrEn && w_chHit && (w_chSel == 8'(k)) && (w_regSel == 2'd2);
         w_wrStat[k] = w_wrEn && w_chHit && (w_chSel == 8'(k)) && (w_regSel == 2'd3);
         w_start[k]  = w_wrEn && w_startHit && w_wdataMasked[k];
         w_tick[k]   = r_en[k] && (r_pc[k] == r_presc[k]);
         if (w_tick[k]) begin
            if (r_cnt[k] == r_cmp[k]) begin
               w_setMatch[k] = 1'b1;
               w_hwStop[k]   = ~r_periodic[k];
               w_cntHw[k]    = '0;
            end else if (&r_cnt[k]) begin
               w_setOvf[k]   = 1'b1;
               w_cntHw[k]    = '0;
            end else begin
               w_cntHw[k]    = r_cnt[k] + 1'b1;
            end
         end
      end
   end

   // Channel state, interrupt levels and the one-cycle response pipeline.
   // Software writes override hardware updates, START overrides a CTRL.EN
   // write, and a hardware flag set overrides a same-cycle clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_en       <= '0;
         r_periodic <= '0;
         r_matchIe  <= '0;
         r_ovfIe    <= '0;
         r_match    <= '0;
         r_ovf      <= '0;
         for (int k = 0; k < NumTimers; k++) begin
            r_presc[k] <= '0;
            r_pc[k]    <= '0;
            r_cnt[k]   <= '0;
            r_cmp[k]   <= '0;
         end
         r_irq      <= '0;
         r_rspValid <= 1'b0;
         r_rspError <= 1'b0;
         r_rspRdata <= '0;
      end else begin
         for (int k = 0; k < NumTimers; k++) begin
            if (r_en[k]) begin
               r_pc[k] <= w_tick[k] ? '0 : r_pc[k] + 1'b1;
            end
            r_cnt[k] <= w_wrCnt[k] ? w_wrMerged[CntWidth-1:0] : w_cntHw[k];
            if (w_wrCmp[k]) begin
               r_cmp[k] <= w_wrMerged[CntWidth-1:0];
            end
            if (w_wrCtrl[k]) begin
               r_en[k]       <= w_wrMerged[0];
               r_periodic[k] <= w_wrMerged[1];
               r_matchIe[k]  <= w_wrMerged[2];
               r_ovfIe[k]    <= w_wrMerged[3];
               r_presc[k]    <= w_wrMerged[8 +: PrescWidth];
            end else if (w_hwStop[k]) begin
               r_en[k] <= 1'b0;
            end
            if (w_start[k]) begin
               r_en[k] <= 1'b1;
               r_pc[k] <= '0;
            end
            r_match[k]     <= (r_match[k] & ~(w_wrStat[k] & w_wdataMasked[0])) | w_setMatch[k];
            r_ovf[k]       <= (r_ovf[k] & ~(w_wrStat[k] & w_wdataMasked[1])) | w_setOvf[k];
            r_irq[2*k]     <= r_match[k] & r_matchIe[k];
            r_irq[2*k + 1] <= r_ovf[k] & r_ovfIe[k];
         end
         r_rspValid <= req_valid_i;
         r_rspError <= req_valid_i & w_err;
         r_rspRdata <= (req_valid_i & ~req_write_i & ~w_err) ? w_rdImage : '0;
      end
   end

endmodule
